// File: rtl/song_sequencer_pkg.sv
// Shared definitions for the song sequencer: field widths, FSM state codes, ROM word field helpers.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package song_sequencer_pkg;

    localparam int SONG_W = 2;                // 4 songs
    localparam int IDX_W  = 5;                // 32 ROM words per song
    localparam int NOTE_W = 6;                // note code, matches note_player note_to_load
    localparam int DUR_W  = 6;                // duration in 1/48 s beats
    localparam int WORD_W = NOTE_W + DUR_W;   // ROM word {note, duration}
    localparam int ADDR_W = SONG_W + IDX_W;   // ROM address {song, idx}

    localparam logic [2:0] FETCH    = 3'd0;
    localparam logic [2:0] DECODE   = 3'd1;
    localparam logic [2:0] LOAD     = 3'd2;
    localparam logic [2:0] SETTLE   = 3'd3;
    localparam logic [2:0] PLAYING  = 3'd4;
    localparam logic [2:0] ADVANCE  = 3'd5;
    localparam logic [2:0] SONG_END = 3'd6;

    localparam logic [IDX_W-1:0] IDX_LAST = '1;

    function automatic logic [NOTE_W-1:0] word_note(input logic [WORD_W-1:0] w);
        return w[WORD_W-1:DUR_W];
    endfunction

    // A zero duration is the end-of-song marker.
    function automatic logic [DUR_W-1:0] word_dur(input logic [WORD_W-1:0] w);
        return w[DUR_W-1:0];
    endfunction

endpackage

// File: rtl/song_sequencer.sv
// Steps through a song in an external synchronous ROM and hands each note to note_player.
// Latency: FETCH entry to new_note pulse 2 cycles; note_done to next new_note 4 cycles (play=1).
// Backpressure: play=0 holds in LOAD/PLAYING; note_done gates advancing to the next note.
//
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   play            1 = run, 0 = pause
//   song            selected song; any change restarts from word 0 of the new song
//   rom_addr        {song_latched, idx} to song ROM (combinational from registers)
//   rom_data        {note, duration}, valid one cycle after rom_addr
//   note_done       note_player done_with_note (level)
//   note_out        note_player note_to_load
//   duration_out    note_player duration_to_load
//   new_note        one-cycle load pulse to note_player
//   song_done       level, current song finished
module song_sequencer
    import song_sequencer_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              play,
    input  logic [SONG_W-1:0] song,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [WORD_W-1:0] rom_data,
    input  logic              note_done,
    output logic [NOTE_W-1:0] note_out,
    output logic [DUR_W-1:0]  duration_out,
    output logic              new_note,
    output logic              song_done
);

    logic [2:0]        state_q,     state_d;
    logic [IDX_W-1:0]  idx_q,       idx_d;
    logic [SONG_W-1:0] song_q,      song_d;
    logic [NOTE_W-1:0] note_q,      note_d;
    logic [DUR_W-1:0]  dur_q,       dur_d;
    logic              new_note_q,  new_note_d;
    logic              song_done_q, song_done_d;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        song_d      = song_q;
        note_d      = note_q;
        dur_d       = dur_q;
        new_note_d  = 1'b0;
        song_done_d = song_done_q;

        if (song != song_q) begin
            // Song change overrides everything; the note in flight is abandoned.
            song_d      = song;
            idx_d       = '0;
            song_done_d = 1'b0;
            state_d     = FETCH;
        end else begin
            case (state_q)
                FETCH: state_d = DECODE;
                DECODE: begin
                    if (word_dur(rom_data) == '0) begin
                        state_d     = SONG_END;
                        song_done_d = 1'b1;
                    end else begin
                        note_d     = word_note(rom_data);
                        dur_d      = word_dur(rom_data);
                        state_d    = LOAD;
                        // Pulse is registered, so it is armed on the way into LOAD.
                        new_note_d = play;
                    end
                end
                LOAD: begin
                    // new_note_q high means the pulse is being emitted this cycle.
                    if (new_note_q) begin
                        state_d = SETTLE;
                    end else begin
                        new_note_d = play;
                    end
                end
                // note_player still shows the previous note's done here.
                SETTLE: state_d = PLAYING;
                PLAYING: begin
                    if (note_done && play) begin
                        state_d = ADVANCE;
                    end
                end
                ADVANCE: begin
                    if (idx_q == IDX_LAST) begin
                        state_d     = SONG_END;
                        song_done_d = 1'b1;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = FETCH;
                    end
                end
                SONG_END: state_d = SONG_END;
                default:  state_d = FETCH;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= FETCH;
            idx_q       <= '0;
            song_q      <= song;
            note_q      <= '0;
            dur_q       <= '0;
            new_note_q  <= 1'b0;
            song_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            song_q      <= song_d;
            note_q      <= note_d;
            dur_q       <= dur_d;
            new_note_q  <= new_note_d;
            song_done_q <= song_done_d;
        end
    end

    assign rom_addr     = {song_q, idx_q};
    assign note_out     = note_q;
    assign duration_out = dur_q;
    assign new_note     = new_note_q;
    assign song_done    = song_done_q;

endmodule

// File: tb/tb_song_sequencer.sv
// Self-checking bench for song_sequencer: ROM and note_player models, pulse scoreboard, directed + random scenarios.
// Latency: n/a (testbench).
// Backpressure: play toggled directly; note_done from a beat-counting note_player model or forced high.
module tb_song_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        play = 1'b1;
    logic [1:0]  song = 2'd0;
    logic [6:0]  rom_addr;
    logic [11:0] rom_data = 12'd0;
    logic        note_done;
    logic [5:0]  note_out;
    logic [5:0]  duration_out;
    logic        new_note;
    logic        song_done;

    int compared = 0;
    int mismatched = 0;

    logic [11:0] rom [128];

    // note_player model: two clock cycles per beat, counting only while playing.
    int   np_cnt = 0;
    logic np_done = 1'b0;
    logic force_done = 1'b0;

    // Scoreboard state: song the DUT is expected to be playing and pulses seen for it.
    logic [1:0] mon_song = 2'd0;
    int         mon_k = 0;

    song_sequencer dut (
        .clk          (clk),
        .reset        (reset),
        .play         (play),
        .song         (song),
        .rom_addr     (rom_addr),
        .rom_data     (rom_data),
        .note_done    (note_done),
        .note_out     (note_out),
        .duration_out (duration_out),
        .new_note     (new_note),
        .song_done    (song_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) rom_data <= rom[rom_addr];

    assign note_done = np_done | force_done;

    always @(posedge clk) begin
        if (reset) begin
            np_cnt  <= 0;
            np_done <= 1'b0;
        end else if (new_note) begin
            np_done <= 1'b0;
            np_cnt  <= 2 * int'(duration_out);
        end else if (play && np_cnt != 0) begin
            np_cnt <= np_cnt - 1;
            if (np_cnt == 1) np_done <= 1'b1;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Notes in a song: words up to the first zero duration, at most 32.
    function automatic int song_len(input int s);
        for (int i = 0; i < 32; i++)
            if (rom[s*32 + i][5:0] == 6'd0) return i;
        return 32;
    endfunction

    // Fill song s with n playable notes followed by an end marker (none when n >= 32).
    task automatic load_song(input int s, input int n);
        logic [11:0] w;
        for (int i = 0; i < 32; i++) begin
            w[11:6] = 6'($urandom);
            w[5:0]  = (i == n) ? 6'd0 : 6'($urandom_range(1, 4));
            rom[s*32 + i] = w;
        end
    endtask

    // Each pulse must carry the next word of the current song and stay within the song.
    always @(negedge clk) begin
        if (new_note) begin
            check_eq("pulse_in_song", 32'(mon_k < song_len(int'(mon_song))), 32'd1);
            check_eq("pulse_note", 32'(note_out), 32'(rom[int'(mon_song)*32 + (mon_k % 32)][11:6]));
            check_eq("pulse_dur", 32'(duration_out), 32'(rom[int'(mon_song)*32 + (mon_k % 32)][5:0]));
            mon_k++;
        end
        // reset and song are sampled by the DUT at the coming edge.
        if (reset || song != mon_song) begin
            mon_song = song;
            mon_k    = 0;
        end
    end

    // Counts cycles (negedges) without a pulse before the pulse is seen.
    task automatic wait_pulse(input int bound, output int n);
        n = 0;
        while (n < bound) begin
            @(negedge clk);
            if (new_note) return;
            n++;
        end
        check_eq("pulse_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_done(input int bound);
        for (int c = 0; c < bound; c++) begin
            @(posedge clk);
            #1;
            @(negedge clk);
            if (song_done) return;
        end
        check_eq("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_addr"}, 32'(rom_addr), 32'd0);
        check_eq({tag, "_note"}, 32'(note_out), 32'd0);
        check_eq({tag, "_dur"}, 32'(duration_out), 32'd0);
        check_eq({tag, "_new"}, 32'(new_note), 32'd0);
        check_eq({tag, "_done"}, 32'(song_done), 32'd0);
    endtask

    initial begin
        int n;
        int cyc;
        int len;
        int at;
        bit chg;
        logic [1:0] s2;
        logic [1:0] s3;

        for (int s = 0; s < 4; s++) load_song(s, 32);

        // 1: two-note song with end marker
        rom[0] = {6'd37, 6'd12};
        rom[1] = {6'd40, 6'd6};
        rom[2] = {6'd5, 6'd0};
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        check_reset_outputs("reset");
        reset = 1'b0;
        wait_pulse(20, n);
        check_eq("first_pulse_latency", 32'(n), 32'd2);
        check_eq("t1_note0", 32'(note_out), 32'd37);
        check_eq("t1_dur0", 32'(duration_out), 32'd12);
        n = 0;
        while (!note_done && n < 200) begin
            @(negedge clk);
            n++;
        end
        check_eq("t1_done_seen", 32'(note_done), 32'd1);
        wait_pulse(20, n);
        // n excludes the cycle in which note_done was first seen
        check_eq("done_to_pulse_latency", 32'(n + 1), 32'd4);
        check_eq("t1_note1", 32'(note_out), 32'd40);
        wait_done(300);
        check_eq("t1_pulses", 32'(mon_k), 32'd2);
        check_eq("t1_addr_end", 32'(rom_addr), 32'd2);
        repeat (5) @(posedge clk);
        #1;
        check_eq("t1_addr_hold", 32'(rom_addr), 32'd2);
        check_eq("t1_done_hold", 32'(song_done), 32'd1);
        check_eq("t1_pulses_hold", 32'(mon_k), 32'd2);

        // 2: pause while PLAYING with note_done high
        load_song(1, 3);
        @(posedge clk);
        #1;
        song = 2'd1;
        wait_pulse(20, n);
        @(posedge clk);
        #1;
        play = 1'b0;
        force_done = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check_eq("pause_idx_hold", 32'(rom_addr), 32'd32);
        check_eq("pause_no_pulse", 32'(mon_k), 32'd1);
        play = 1'b1;
        wait_pulse(20, n);
        check_eq("unpause_latency", 32'(n), 32'd4);
        force_done = 1'b0;
        wait_done(300);
        check_eq("t2_pulses", 32'(mon_k), 32'd3);
        check_eq("t2_addr_end", 32'(rom_addr), 32'd35);

        // 3: song change while PLAYING idx 5
        load_song(0, 10);
        load_song(2, 4);
        @(posedge clk);
        #1;
        song = 2'd0;
        for (int i = 0; i < 6; i++) wait_pulse(100, n);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        check_eq("t3_addr_idx5", 32'(rom_addr), 32'd5);
        song = 2'd2;
        @(posedge clk);
        #1;
        check_eq("t3_addr_restart", 32'(rom_addr), 32'd64);
        check_eq("t3_done_clear", 32'(song_done), 32'd0);
        wait_pulse(20, n);
        check_eq("t3_new_song_note", 32'(note_out), 32'(rom[64][11:6]));
        wait_done(300);
        check_eq("t3_pulses", 32'(mon_k), 32'd4);

        // 4: full 32-note song, no wrap
        load_song(3, 32);
        @(posedge clk);
        #1;
        song = 2'd3;
        wait_done(4000);
        check_eq("t4_pulses", 32'(mon_k), 32'd32);
        check_eq("t4_addr_end", 32'(rom_addr), 32'd127);
        check_eq("t4_done", 32'(song_done), 32'd1);
        repeat (10) @(posedge clk);
        #1;
        check_eq("t4_addr_hold", 32'(rom_addr), 32'd127);
        check_eq("t4_pulses_hold", 32'(mon_k), 32'd32);

        // 5: note_done stuck high, one pulse per note
        load_song(1, 5);
        force_done = 1'b1;
        @(posedge clk);
        #1;
        song = 2'd1;
        wait_done(500);
        check_eq("t5_pulses", 32'(mon_k), 32'd5);
        check_eq("t5_addr_end", 32'(rom_addr), 32'd37);
        force_done = 1'b0;

        // 6: reset in PLAYING idx 7
        load_song(0, 12);
        @(posedge clk);
        #1;
        song = 2'd0;
        for (int i = 0; i < 8; i++) wait_pulse(100, n);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        check_eq("t6_addr_idx7", 32'(rom_addr), 32'd7);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_reset_outputs("midreset");
        reset = 1'b0;
        wait_pulse(20, n);
        check_eq("t6_reload_latency", 32'(n), 32'd2);
        check_eq("t6_reload_note", 32'(note_out), 32'(rom[0][11:6]));
        check_eq("t6_reload_dur", 32'(duration_out), 32'(rom[0][5:0]));

        // Random songs, random pausing, occasional mid-song switch
        for (int r = 0; r < 8; r++) begin
            s2 = 2'((int'(song) + 1 + int'($urandom_range(0, 2))) % 4);
            load_song(int'(s2), int'($urandom_range(0, 33)));
            chg = (r % 2) == 1;
            s3 = 2'((int'(s2) + 1 + int'($urandom_range(0, 2))) % 4);
            at = int'($urandom_range(3, 60));
            if (chg) load_song(int'(s3), int'($urandom_range(1, 10)));
            @(posedge clk);
            #1;
            song = s2;
            for (cyc = 0; cyc < 6000; cyc++) begin
                @(posedge clk);
                #1;
                play = ($urandom_range(0, 3) != 0);
                if (chg && cyc == at) song = s3;
                @(negedge clk);
                if (song_done && (!chg || cyc > at)) break;
            end
            check_eq("rnd_finished", 32'(cyc < 6000), 32'd1);
            len = song_len(int'(song));
            check_eq("rnd_pulses", 32'(mon_k), 32'(len));
            check_eq("rnd_addr_end", 32'(rom_addr), 32'(int'(song) * 32 + ((len == 32) ? 31 : len)));
            play = 1'b1;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
